// File: rtl/bb_system_stepper.sv
// bb_system_stepper
//   Run/step/breakpoint controller for a datapath clock enable, with an
//   enabled-cycle counter and a registered display-channel mux.
//
// Ports
//   BB_SYSTEM_STEPPER_CLOCK_50             clock, all state on rising edge
//   BB_SYSTEM_STEPPER_Reset_InLow          asynchronous active-low reset
//   BB_SYSTEM_STEPPER_Mode_In[1:0]         00 HALT, 01 RUN, 10 STEP, 11 HALT
//   BB_SYSTEM_STEPPER_Step_In              step request (rising edge = event)
//   BB_SYSTEM_STEPPER_BreakEnable_In       breakpoint enable
//   BB_SYSTEM_STEPPER_BreakAddr_In         breakpoint address
//   BB_SYSTEM_STEPPER_PC_In                datapath PC
//   BB_SYSTEM_STEPPER_Channels_In          concatenated buses, channel 0 in LSBs
//   BB_SYSTEM_STEPPER_ChSel_In             display channel select
//   BB_SYSTEM_STEPPER_CountClear_In        synchronous cycle-counter clear
//   BB_SYSTEM_STEPPER_DatapathEnable_Out   combinational datapath clock enable
//   BB_SYSTEM_STEPPER_State_Out[1:0]       IDLE 00, RUN 01, STEP 10, BREAK 11
//   BB_SYSTEM_STEPPER_BreakHit_Out         high while in BREAK
//   BB_SYSTEM_STEPPER_CycleCount_Out       number of enabled datapath cycles
//   BB_SYSTEM_STEPPER_DataBUSDisplay_Out   registered selected channel
module bb_system_stepper #(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CHSEL_WIDTH   = 2,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                                  BB_SYSTEM_STEPPER_CLOCK_50,
  input  logic                                  BB_SYSTEM_STEPPER_Reset_InLow,
  input  logic [1:0]                            BB_SYSTEM_STEPPER_Mode_In,
  input  logic                                  BB_SYSTEM_STEPPER_Step_In,
  input  logic                                  BB_SYSTEM_STEPPER_BreakEnable_In,
  input  logic [DATAWIDTH_BUS-1:0]              BB_SYSTEM_STEPPER_BreakAddr_In,
  input  logic [DATAWIDTH_BUS-1:0]              BB_SYSTEM_STEPPER_PC_In,
  input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] BB_SYSTEM_STEPPER_Channels_In,
  input  logic [CHSEL_WIDTH-1:0]                BB_SYSTEM_STEPPER_ChSel_In,
  input  logic                                  BB_SYSTEM_STEPPER_CountClear_In,
  output logic                                  BB_SYSTEM_STEPPER_DatapathEnable_Out,
  output logic [1:0]                            BB_SYSTEM_STEPPER_State_Out,
  output logic                                  BB_SYSTEM_STEPPER_BreakHit_Out,
  output logic [COUNT_WIDTH-1:0]                BB_SYSTEM_STEPPER_CycleCount_Out,
  output logic [DATAWIDTH_BUS-1:0]              BB_SYSTEM_STEPPER_DataBUSDisplay_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  logic                     clk;
  logic                     rst_n;
  mode_e                    mode;
  state_e                   state;
  state_e                   state_next;
  logic                     step_prev;
  logic                     step_event;
  logic                     match;
  logic                     dp_enable;
  logic [COUNT_WIDTH-1:0]   cycle_count;
  logic [DATAWIDTH_BUS-1:0] display;
  logic [DATAWIDTH_BUS-1:0] display_next;

  assign clk   = BB_SYSTEM_STEPPER_CLOCK_50;
  assign rst_n = BB_SYSTEM_STEPPER_Reset_InLow;
  assign mode  = mode_e'(BB_SYSTEM_STEPPER_Mode_In);

  assign step_event = BB_SYSTEM_STEPPER_Step_In & ~step_prev;
  assign match      = BB_SYSTEM_STEPPER_BreakEnable_In &
                      (BB_SYSTEM_STEPPER_PC_In == BB_SYSTEM_STEPPER_BreakAddr_In);

  // Enable is decoded from the current PC, so the datapath is held on the
  // very cycle the breakpoint address appears rather than one cycle later.
  assign dp_enable = (state == ST_STEP) || ((state == ST_RUN) && !match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step_prev <= 1'b0;
    end else begin
      state     <= state_next;
      step_prev <= BB_SYSTEM_STEPPER_Step_In;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_RUN)
          state_next = ST_RUN;
        else if ((mode == MODE_STEP) && step_event)
          state_next = ST_STEP;
      end
      ST_RUN: begin
        if (mode != MODE_RUN)
          state_next = ST_IDLE;
        else if (match)
          state_next = ST_BREAK;
      end
      ST_STEP: state_next = ST_IDLE;
      ST_BREAK: begin
        // RUN alone keeps the breakpoint latched; only a step or halt leaves.
        if ((mode == MODE_HALT) || (mode == MODE_RSVD))
          state_next = ST_IDLE;
        else if (step_event)
          state_next = ST_STEP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_count <= '0;
    else if (BB_SYSTEM_STEPPER_CountClear_In)
      cycle_count <= '0;
    else if (dp_enable)
      cycle_count <= cycle_count + COUNT_WIDTH'(1);
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    display_next = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (32'(BB_SYSTEM_STEPPER_ChSel_In) == i)
        display_next = BB_SYSTEM_STEPPER_Channels_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      display <= '0;
    else
      display <= display_next;
  end

  assign BB_SYSTEM_STEPPER_DatapathEnable_Out = dp_enable;
  assign BB_SYSTEM_STEPPER_State_Out          = state;
  assign BB_SYSTEM_STEPPER_BreakHit_Out       = (state == ST_BREAK);
  assign BB_SYSTEM_STEPPER_CycleCount_Out     = cycle_count;
  assign BB_SYSTEM_STEPPER_DataBUSDisplay_Out = display;

endmodule

// File: tb/tb_bb_system_stepper.sv
// tb_bb_system_stepper
//   Scoreboard bench for bb_system_stepper (CHSEL_WIDTH=3 so out-of-range
//   channel selects can be driven). Expected post-edge values are pushed
//   when a cycle's stimulus is driven and popped after the edge.
module tb_bb_system_stepper;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 4;
  localparam int unsigned CSW = 3;
  localparam int unsigned CW  = 16;

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode;
  logic              step;
  logic              brk_en;
  logic [DW-1:0]     brk_addr;
  logic [DW-1:0]     pc;
  logic [NCH*DW-1:0] channels;
  logic [CSW-1:0]    chsel;
  logic              clr;
  logic              en_out;
  logic [1:0]        state_out;
  logic              hit_out;
  logic [CW-1:0]     count_out;
  logic [DW-1:0]     disp_out;

  bb_system_stepper #(
    .DATAWIDTH_BUS(DW),
    .NUM_CHANNELS (NCH),
    .CHSEL_WIDTH  (CSW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .BB_SYSTEM_STEPPER_CLOCK_50          (clk),
    .BB_SYSTEM_STEPPER_Reset_InLow       (rst_n),
    .BB_SYSTEM_STEPPER_Mode_In           (mode),
    .BB_SYSTEM_STEPPER_Step_In           (step),
    .BB_SYSTEM_STEPPER_BreakEnable_In    (brk_en),
    .BB_SYSTEM_STEPPER_BreakAddr_In      (brk_addr),
    .BB_SYSTEM_STEPPER_PC_In             (pc),
    .BB_SYSTEM_STEPPER_Channels_In       (channels),
    .BB_SYSTEM_STEPPER_ChSel_In          (chsel),
    .BB_SYSTEM_STEPPER_CountClear_In     (clr),
    .BB_SYSTEM_STEPPER_DatapathEnable_Out(en_out),
    .BB_SYSTEM_STEPPER_State_Out         (state_out),
    .BB_SYSTEM_STEPPER_BreakHit_Out      (hit_out),
    .BB_SYSTEM_STEPPER_CycleCount_Out    (count_out),
    .BB_SYSTEM_STEPPER_DataBUSDisplay_Out(disp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [DW-1:0] disp;
  } exp_t;

  exp_t sb[$];

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [1:0]    m_state;
  logic          m_prev;
  logic [CW-1:0] m_count;
  logic          rand_ch;
  logic          track_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_prev  = 1'b0;
    m_count = '0;
    sb.delete();
  endtask

  // One clock cycle: predict, check the pre-edge enable, cross the edge,
  // then compare the popped expectation with the registered outputs.
  task automatic run_cycle();
    exp_t       e;
    logic       m;
    logic       en;
    logic       ev;
    logic [1:0] ns;
    if (rand_ch) begin
      channels = {$urandom, $urandom, $urandom, $urandom};
      chsel    = 3'($urandom_range(0, 7));
    end
    #1;
    m  = brk_en && (pc == brk_addr);
    en = (m_state == 2'd2) || ((m_state == 2'd1) && !m);
    check("enable", {63'd0, en_out}, {63'd0, en});
    ev = step && !m_prev;
    case (m_state)
      2'd0:    ns = (mode == 2'd1) ? 2'd1 : ((mode == 2'd2) && ev) ? 2'd2 : 2'd0;
      2'd1:    ns = (mode != 2'd1) ? 2'd0 : m ? 2'd3 : 2'd1;
      2'd2:    ns = 2'd0;
      default: ns = ((mode == 2'd0) || (mode == 2'd3)) ? 2'd0 : ev ? 2'd2 : 2'd3;
    endcase
    if (clr)
      m_count = '0;
    else if (en)
      m_count = m_count + 16'd1;
    e.st   = ns;
    e.cnt  = m_count;
    e.disp = (chsel < 3'd4) ? channels[int'(chsel)*DW +: DW] : '0;
    m_state = ns;
    m_prev  = step;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("state",    {62'd0, state_out}, {62'd0, e.st});
    check("breakhit", {63'd0, hit_out},   {63'd0, (e.st == 2'd3)});
    check("count",    {48'd0, count_out}, {48'd0, e.cnt});
    check("display",  {32'd0, disp_out},  {32'd0, e.disp});
    if (track_pc && en)
      pc = pc + 32'd4;
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      run_cycle();
  endtask

  logic [DW-1:0] ch_exp [8];

  initial begin
    rst_n    = 1'b0;
    mode     = 2'd0;
    step     = 1'b0;
    brk_en   = 1'b0;
    brk_addr = '0;
    pc       = '0;
    channels = '0;
    chsel    = '0;
    clr      = 1'b0;
    rand_ch  = 1'b1;
    track_pc = 1'b0;
    model_reset();

    // Reset values
    #3;
    check("rst_enable", {63'd0, en_out},    64'd0);
    check("rst_state",  {62'd0, state_out}, 64'd0);
    check("rst_hit",    {63'd0, hit_out},   64'd0);
    check("rst_count",  {48'd0, count_out}, 64'd0);
    check("rst_disp",   {32'd0, disp_out},  64'd0);
    #9 rst_n = 1'b1;

    // RUN for ten edges, then HALT: ten enabled cycles
    mode = 2'd1;
    run_cycle();
    check("first_edge_run", {62'd0, state_out}, 64'd1);
    cycles(9);
    mode = 2'd0;
    run_cycle();
    check("run10_count", {48'd0, count_out}, 64'd10);
    check("run10_state", {62'd0, state_out}, 64'd0);

    // Mode 11 behaves as HALT even with a step event; clear the counter too
    mode = 2'd3; step = 1'b1; clr = 1'b1;
    run_cycle();
    check("mode3_idle", {62'd0, state_out}, 64'd0);
    check("clr_idle",   {48'd0, count_out}, 64'd0);
    step = 1'b0; clr = 1'b0; mode = 2'd0;
    run_cycle();

    // STEP with Step held for five cycles: exactly one enabled cycle
    mode = 2'd2; step = 1'b1;
    run_cycle();
    check("step_entered", {62'd0, state_out}, 64'd2);
    cycles(4);
    check("step_count", {48'd0, count_out}, 64'd1);
    check("step_idle",  {62'd0, state_out}, 64'd0);
    step = 1'b0;
    run_cycle();

    // Breakpoint at 0x810 with the PC advancing from 0x800
    mode = 2'd0; clr = 1'b1;
    run_cycle();
    clr = 1'b0;
    pc = 32'h0000_0800; brk_addr = 32'h0000_0810; brk_en = 1'b1;
    track_pc = 1'b1; mode = 2'd1;
    cycles(8);
    check("brk_count", {48'd0, count_out}, 64'd4);
    check("brk_state", {62'd0, state_out}, 64'd3);
    check("brk_hit",   {63'd0, hit_out},   64'd1);
    check("brk_en0",   {63'd0, en_out},    64'd0);
    cycles(2);
    check("brk_run_holds", {62'd0, state_out}, 64'd3);
    mode = 2'd2; step = 1'b1;
    run_cycle();
    check("brk_step", {62'd0, state_out}, 64'd2);
    run_cycle();
    check("brk_step_count", {48'd0, count_out}, 64'd5);
    check("brk_step_idle",  {62'd0, state_out}, 64'd0);
    step = 1'b0; track_pc = 1'b0;
    run_cycle();

    // Entering RUN already at the breakpoint: zero enabled cycles
    pc = 32'h0000_0810; mode = 2'd1;
    cycles(2);
    check("atbrk_state", {62'd0, state_out}, 64'd3);
    check("atbrk_count", {48'd0, count_out}, 64'd5);
    mode = 2'd3;
    run_cycle();
    check("brk_mode3_idle", {62'd0, state_out}, 64'd0);
    mode = 2'd1;
    run_cycle();
    mode = 2'd0;
    run_cycle();
    check("halt_over_match", {62'd0, state_out}, 64'd0);

    // Counter wrap and clear-over-increment
    brk_en = 1'b0; clr = 1'b1;
    run_cycle();
    clr = 1'b0; mode = 2'd1;
    cycles(65536);
    check("count_ffff", {48'd0, count_out}, 64'hFFFF);
    run_cycle();
    check("count_wrap", {48'd0, count_out}, 64'd0);
    cycles(3);
    clr = 1'b1;
    run_cycle();
    check("clr_wins", {48'd0, count_out}, 64'd0);
    clr = 1'b0; mode = 2'd0;
    run_cycle();

    // Display mux over every select value
    rand_ch  = 1'b0;
    ch_exp[0] = 32'hA0A0_0001; ch_exp[1] = 32'hB1B1_0002;
    ch_exp[2] = 32'hC2C2_0003; ch_exp[3] = 32'hD3D3_0004;
    for (int i = 4; i < 8; i++) ch_exp[i] = '0;
    channels = {ch_exp[3], ch_exp[2], ch_exp[1], ch_exp[0]};
    for (int i = 0; i < 8; i++) begin
      chsel = 3'(i);
      run_cycle();
      check($sformatf("chsel%0d", i), {32'd0, disp_out}, {32'd0, ch_exp[i]});
    end
    rand_ch = 1'b1;

    // Asynchronous reset mid-RUN
    mode = 2'd1;
    cycles(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_enable", {63'd0, en_out},    64'd0);
    check("arst_state",  {62'd0, state_out}, 64'd0);
    check("arst_hit",    {63'd0, hit_out},   64'd0);
    check("arst_count",  {48'd0, count_out}, 64'd0);
    check("arst_disp",   {32'd0, disp_out},  64'd0);
    model_reset();
    #2 rst_n = 1'b1;
    run_cycle();
    check("post_rst_run", {62'd0, state_out}, 64'd1);
    mode = 2'd0;
    cycles(2);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
